// File: rtl/wb_keypad_pkg.sv
// Shared definitions for the Wishbone keypad scanner: register map,
// register bit positions and scanner FSM states.
package wb_keypad_pkg;

  // Register offsets (word index taken from wb_adr_i[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // DATA register
  localparam int DATA_VALID_BIT  = 31;

  // STATUS register
  localparam int STAT_OVF_BIT    = 16;
  localparam int STAT_EMPTY_BIT  = 17;
  localparam int STAT_FULL_BIT   = 18;

  // CTRL register
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  // Scanner FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DEBOUNCE = 2'd2,
    HELD     = 2'd3
  } kp_state_e;

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO for key codes. Flush dominates push/pop; a push
// into a full FIFO is accepted only when a pop frees a slot on the same edge.
module keypad_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; no reset needed on the data array
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/wb_keypad_scanner.sv
// Wishbone keypad scanner: active-low column scan, debounced press/release
// tracking, key-code FIFO with sticky overflow.
// Optional interrupt output enabled by defining KEYPAD_IRQ_EN.
module wb_keypad_scanner
  import wb_keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 16,
  parameter int DEB_CYC    = 250000,
  parameter int FIFO_DEPTH = 8,
  localparam int CODE_W = $clog2(ROWS*COLS),
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  input  logic [ROWS-1:0]   rows_i,
  output logic [COLS-1:0]   cols_o,
  output logic [CODE_W-1:0] key_last,
  output logic              irq_o
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYC);
  localparam int DEB_W = $clog2(DEB_CYC) + 1;

  logic [ROWS-1:0]   rows_p0;
  logic [ROWS-1:0]   rows_p1;
  kp_state_e         state, state_n;
  logic [COL_W-1:0]  col_q, col_n, col_next;
  logic [ROW_W-1:0]  row_q, row_n, low_idx;
  logic [SET_W-1:0]  set_q, set_n;
  logic [DEB_W-1:0]  deb_q, deb_n;
  logic [COLS-1:0]   cols_q, cols_n;
  logic              any_low;
  logic              key_push;
  logic [CODE_W-1:0] key_code;

  logic              ack_q;
  logic              bus_acc;
  logic              enable;
  logic              irq_en;
  logic              overflow;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              ovf_clr;
  logic [CODE_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_bits;

  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

  // Two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_p0 <= '1;
      rows_p1 <= '1;
    end else begin
      rows_p0 <= rows_i;
      rows_p1 <= rows_p0;
    end
  end

  // Lowest-index active row in the current column
  always_comb begin
    low_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rows_p1[r]) low_idx = ROW_W'(r);
    end
  end

  assign any_low  = ~&rows_p1;
  assign col_next = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
  assign key_code = CODE_W'(int'(row_q) * COLS + int'(col_q));

  // Scanner FSM state register; column drive is registered alongside
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SCAN;
      col_q  <= '0;
      row_q  <= '0;
      set_q  <= '0;
      deb_q  <= '0;
      cols_q <= '1;
    end else begin
      state  <= state_n;
      col_q  <= col_n;
      row_q  <= row_n;
      set_q  <= set_n;
      deb_q  <= deb_n;
      cols_q <= cols_n;
    end
  end

  // Scanner next-state logic and key push strobe
  always_comb begin
    state_n  = state;
    col_n    = col_q;
    row_n    = row_q;
    set_n    = set_q;
    deb_n    = deb_q;
    key_push = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      set_n   = '0;
      deb_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SCAN;
          col_n   = '0;
          set_n   = '0;
        end
        SCAN: begin
          if (set_q == SET_W'(SETTLE_CYC - 1)) begin
            set_n = '0;
            if (any_low) begin
              state_n = DEBOUNCE;
              row_n   = low_idx;
              deb_n   = '0;
            end else begin
              col_n = col_next;
            end
          end else begin
            set_n = set_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows_p1[row_q]) begin
            state_n = SCAN;
            col_n   = col_next;
            set_n   = '0;
          end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
            key_push = 1'b1;
            state_n  = HELD;
            deb_n    = '0;
          end else begin
            deb_n = deb_q + 1'b1;
          end
        end
        HELD: begin
          if (!rows_p1[row_q]) begin
            deb_n = '0;
          end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
            state_n = SCAN;
            col_n   = col_next;
            set_n   = '0;
            deb_n   = '0;
          end else begin
            deb_n = deb_q + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    cols_n = (state_n == IDLE) ? '1 : ~(COLS'(1) << col_n);
  end

  assign cols_o = cols_q;

  // Last pushed key code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        key_last <= '0;
    else if (key_push) key_last <= key_code;
  end

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (key_code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus_acc    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_ack_o   = wb_cyc_i & wb_stb_i & ack_q;
  assign fifo_pop   = bus_acc & ~wb_we_i & (wb_adr_i[3:2] == REG_DATA) & ~fifo_empty;
  assign fifo_flush = bus_acc & wb_we_i & (wb_adr_i[3:2] == REG_CTRL) & wb_dat_i[CTRL_FLUSH_BIT];
  assign ovf_clr    = bus_acc & wb_we_i & (wb_adr_i[3:2] == REG_STATUS) & wb_dat_i[STAT_OVF_BIT];

  // Single-cycle ack with one wait state; read data captured on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ack_q <= bus_acc;
      if (bus_acc && !wb_we_i) begin
        wb_dat_o <= '0;
        case (wb_adr_i[3:2])
          REG_DATA: begin
            if (!fifo_empty) begin
              wb_dat_o[DATA_VALID_BIT] <= 1'b1;
              wb_dat_o[CODE_W-1:0]     <= fifo_dout;
            end
          end
          REG_STATUS: begin
            wb_dat_o[CNT_W-1:0]      <= fifo_count;
            wb_dat_o[STAT_OVF_BIT]   <= overflow;
            wb_dat_o[STAT_EMPTY_BIT] <= fifo_empty;
            wb_dat_o[STAT_FULL_BIT]  <= fifo_full;
          end
          REG_CTRL: begin
            wb_dat_o[CTRL_EN_BIT]     <= enable;
            wb_dat_o[CTRL_IRQ_EN_BIT] <= irq_en;
          end
          default: wb_dat_o <= '0;
        endcase
      end
    end
  end

  // Sticky overflow: a new drop beats a clear on the same edge; flush clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   overflow <= 1'b0;
    else if (fifo_flush)                          overflow <= 1'b0;
    else if (key_push && fifo_full && !fifo_pop)  overflow <= 1'b1;
    else if (ovf_clr)                             overflow <= 1'b0;
  end

  // CTRL.enable register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              enable <= 1'b1;
    else if (bus_acc && wb_we_i && wb_adr_i[3:2] == REG_CTRL) enable <= wb_dat_i[CTRL_EN_BIT];
  end

`ifdef KEYPAD_IRQ_EN
  logic irq_q;

  // CTRL.irq_en register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              irq_en <= 1'b0;
    else if (bus_acc && wb_we_i && wb_adr_i[3:2] == REG_CTRL) irq_en <= wb_dat_i[CTRL_IRQ_EN_BIT];
  end

  // Registered interrupt: pending key or overflow while enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= irq_en & (~fifo_empty | overflow);
  end

  assign irq_o = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_keypad_scanner.sv
// Randomised self-checking bench for wb_keypad_scanner with a behavioural
// keypad matrix and a queue-based model of the key FIFO.
module tb_wb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic [ROWS-1:0] rows_i;
  logic [COLS-1:0] cols_o;
  logic [3:0]  key_last;
  logic        irq_o;

  logic [15:0] pressed = '0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          model_q[$];
  bit          model_ovf = 1'b0;

  wb_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(4), .DEB_CYC(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .rows_i(rows_i),
    .cols_o(cols_o), .key_last(key_last), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to a column driven low
  always_comb begin
    rows_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS + c] && !cols_o[c]) rows_i[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check_eq("wr_ack", 32'(wb_ack_o), 32'd1);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wb_adr_i = adr; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    dat = wb_dat_o;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  // FIFO model helpers
  function automatic void model_push(input int code);
    if (model_q.size() < DEPTH) model_q.push_back(code);
    else model_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(model_q.size());
    s[16] = model_ovf;
    s[17] = (model_q.size() == 0);
    s[18] = (model_q.size() == DEPTH);
    return s;
  endfunction

  task automatic check_data_read(input string tag);
    logic [31:0] got, exp;
    wb_read(32'h0, got);
    if (model_q.size() > 0) exp = 32'h8000_0000 | 32'(model_q.pop_front());
    else exp = 32'h0;
    check_eq(tag, got, exp);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] got;
    wb_read(32'h4, got);
    check_eq(tag, got, model_status());
  endtask

  // Stable press long enough to debounce, then release and let scanning resume
  task automatic press_key(input int code, input int cyc);
    pressed = 16'(1) << code;
    repeat (cyc) @(posedge clk);
    pressed = '0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic glitch_key(input int code, input int cyc);
    pressed = 16'(1) << code;
    repeat (cyc) @(posedge clk);
    pressed = '0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int codes[5];
    int code, same, k, r0;
    bit found;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cols", 32'(cols_o), 32'hF);
    check_eq("rst_key_last", 32'(key_last), 32'h0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    check_eq("rst_irq", 32'(irq_o), 32'h0);
    check_eq("rst_ack", 32'(wb_ack_o), 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_status("rst_status");
    wb_read(32'h8, rd);
    check_eq("rst_ctrl", rd, 32'h1);
    wb_read(32'hC, rd);
    check_eq("unmapped", rd, 32'h0);

    // Single press row2/col1
    press_key(9, 40);
    model_push(9);
    check_eq("key_last_9", 32'(key_last), 32'd9);
    check_data_read("data_9");
    check_status("status_after_9");

    // Short bounce gives nothing; stable press gives exactly one
    code = $urandom_range(0, 15);
    glitch_key(code, 3);
    check_status("status_after_glitch");
    press_key(code, 45);
    model_push(code);
    check_status("status_after_stable");
    check_data_read("data_stable");

    // Five distinct presses without reads overflow a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      do begin
        codes[i] = $urandom_range(0, 15);
        found = 1'b0;
        for (int j = 0; j < i; j++) if (codes[j] == codes[i]) found = 1'b1;
      end while (found);
      press_key(codes[i], 40 + $urandom_range(0, 10));
      model_push(codes[i]);
    end
    check_status("status_full_ovf");
    check_eq("status_full_const", model_status(), 32'h0005_0004);
    for (int i = 0; i < 5; i++) check_data_read($sformatf("drain_%0d", i));

    // Two rows in one column: lowest row index wins
    pressed = (16'(1) << 6) | (16'(1) << 14);
    repeat (40) @(posedge clk);
    pressed = '0;
    repeat (40) @(posedge clk);
    #1;
    r0 = -1;
    for (int r = ROWS - 1; r >= 0; r--) if (((16'(1) << 6) | (16'(1) << 14)) & (16'(1) << (r*COLS + 2))) r0 = r;
    model_push(r0*COLS + 2);
    check_eq("multi_key_last", 32'(key_last), 32'(r0*COLS + 2));
    check_status("status_multi");
    wb_write(32'h4, 32'h0001_0000);
    model_ovf = 1'b0;
    check_status("status_ovf_clr");
    wb_write(32'h8, 32'h5);
    model_q.delete();
    check_status("status_flush");

    // Disable while debouncing: scan stops, nothing pushed
    pressed = 16'(1) << 13;
    same = 0; found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      rd[3:0] = cols_o;
      @(negedge clk);
      if (cols_o != 4'hF && cols_o == rd[3:0]) same++;
      else same = 0;
      if (same >= 4) found = 1'b1;
    end
    check_eq("deb_reached", 32'(found), 32'd1);
    wb_write(32'h8, 32'h0);
    check_eq("disable_cols", 32'(cols_o), 32'hF);
    repeat (20) @(posedge clk);
    #1;
    check_eq("idle_cols", 32'(cols_o), 32'hF);
    check_status("status_disabled");
    pressed = '0;
    repeat (4) @(posedge clk);
    #1;
    wb_write(32'h8, 32'h1);
    check_eq("reenable_col0", 32'(cols_o), 32'hE);
    repeat (20) @(posedge clk);
    #1;

    // Randomised presses, glitches and interleaved reads
    for (int i = 0; i < 8; i++) begin
      code = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) glitch_key($urandom_range(0, 15), $urandom_range(1, 3));
      press_key(code, 40 + $urandom_range(0, 25));
      model_push(code);
      check_eq($sformatf("rnd_key_last_%0d", i), 32'(key_last), 32'(code));
      check_status($sformatf("rnd_status_%0d", i));
      if ($urandom_range(0, 2) != 0) check_data_read($sformatf("rnd_data_%0d", i));
    end
    for (int i = 0; i <= DEPTH; i++) check_data_read($sformatf("rnd_drain_%0d", i));
    wb_write(32'h4, 32'h0001_0000);
    model_ovf = 1'b0;
    check_status("status_clean");

    // Interrupt enable bit
    wb_write(32'h8, 32'h3);
    wb_read(32'h8, rd);
`ifdef KEYPAD_IRQ_EN
    check_eq("ctrl_irq_en", rd, 32'h3);
    check_eq("irq_idle", 32'(irq_o), 32'h0);
    press_key(5, 40);
    model_push(5);
    check_eq("irq_on_push", 32'(irq_o), 32'h1);
    check_data_read("irq_data");
    check_eq("irq_after_pop", 32'(irq_o), 32'h0);
`else
    check_eq("ctrl_irq_en", rd, 32'h1);
    press_key(5, 40);
    model_push(5);
    check_eq("irq_tied", 32'(irq_o), 32'h0);
    check_data_read("irq_data");
`endif

    // Asynchronous reset while a key is held
    code = (key_last == 4'd11) ? 7 : 11;
    pressed = 16'(1) << code;
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (key_last == 4'(code)) found = 1'b1;
    end
    check_eq("held_reached", 32'(found), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_cols", 32'(cols_o), 32'hF);
    check_eq("mid_rst_key_last", 32'(key_last), 32'h0);
    check_eq("mid_rst_dat", wb_dat_o, 32'h0);
    check_eq("mid_rst_irq", 32'(irq_o), 32'h0);
    pressed = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status("status_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
